// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Brief    : Recovers hex digits from a multiplexed active-low 7-segment bus
//            (the inverse of the hex-to-segment encoder), with debounce.
// Options  : SEG7_DP_EN adds decimal-point capture (dp_in / dp_out).
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int SETTLE_CYC = 2,
    parameter int STABLE_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
`ifdef SEG7_DP_EN
    input  logic                      dp_in,
    output logic [NUM_DIGITS-1:0]     dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic [NUM_DIGITS-1:0]     digit_err,
    output logic                      update
);

`ifdef SEG7_DP_EN
    localparam int c_CW = 8;
`else
    localparam int c_CW = 7;
`endif

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETTLE = 2'd1;
    localparam logic [1:0] c_SAMPLE = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    localparam logic [3:0]            c_SETTLE_CYC = 4'(SETTLE_CYC);
    localparam logic [2:0]            c_STABLE     = 3'(STABLE_CNT);
    localparam logic [NUM_DIGITS-1:0] c_ONE        = NUM_DIGITS'(1);

    // {valid, value}; anything outside the encoder table is invalid
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        case (p)
            7'b1000000: f_decode = 5'h10;
            7'b1111001: f_decode = 5'h11;
            7'b0100100: f_decode = 5'h12;
            7'b0110000: f_decode = 5'h13;
            7'b0011001: f_decode = 5'h14;
            7'b0010010: f_decode = 5'h15;
            7'b0000010: f_decode = 5'h16;
            7'b1111000: f_decode = 5'h17;
            7'b0000000: f_decode = 5'h18;
            7'b0010000: f_decode = 5'h19;
            7'b0001000: f_decode = 5'h1A;
            7'b0000011: f_decode = 5'h1B;
            7'b1000110: f_decode = 5'h1C;
            7'b0100001: f_decode = 5'h1D;
            7'b0000110: f_decode = 5'h1E;
            7'b0001110: f_decode = 5'h1F;
            default:    f_decode = 5'h00;
        endcase
    endfunction

    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [c_CW-1:0]       w_pat;
    logic [c_CW-1:0]       w_pat_in;
    logic [1:0]            state_q, state_d;
    logic [3:0]            run_q, run_d;
    logic [3:0]            w_run_inc;
    logic                  w_an_chg, w_seg_chg, w_an_onehot, w_sample;
    logic [NUM_DIGITS-1:0] w_an_low;
    logic [4:0]            w_dec;
    logic [NUM_DIGITS-1:0] w_commit;
    logic                  update_q;

`ifdef SEG7_DP_EN
    logic dp_q;
    always_ff @(posedge clk) begin
        if (rst) dp_q <= 1'b1;
        else     dp_q <= dp_in;
    end
    assign w_pat    = {dp_q, seg_q};
    assign w_pat_in = {dp_in, seg_in};
`else
    assign w_pat    = seg_q;
    assign w_pat_in = seg_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 7'h7F;
            an_q  <= '1;
        end else begin
            seg_q <= seg_in;
            an_q  <= an_in;
        end
    end

    // Change flags describe the registered bus at the edge where it updates
    assign w_an_chg    = (an_in != an_q);
    assign w_seg_chg   = (w_pat_in != w_pat);
    assign w_an_low    = ~an_in;
    assign w_an_onehot = (w_an_low != '0) && ((w_an_low & (w_an_low - c_ONE)) == '0);
    assign w_run_inc   = run_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (w_an_chg) begin
            run_d   = '0;
            state_d = w_an_onehot ? c_SETTLE : c_IDLE;
        end else begin
            case (state_q)
                c_IDLE:   state_d = c_IDLE;
                c_SETTLE: begin
                    if (w_seg_chg) begin
                        run_d = '0;
                    end else begin
                        run_d = w_run_inc;
                        if (w_run_inc == c_SETTLE_CYC) state_d = c_SAMPLE;
                    end
                end
                c_SAMPLE: state_d = c_HOLD;
                c_HOLD:   state_d = c_HOLD;
                default:  state_d = c_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sample = (state_q == c_SAMPLE);
    end

    assign w_dec = f_decode(seg_q);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [c_CW-1:0] cand_q;
        logic [2:0]      cnt_q;
        logic [3:0]      val_q;
        logic            valid_q, err_q;
        logic            w_hit, w_match;

        assign w_hit       = w_sample && !an_q[i];
        assign w_match     = (w_pat == cand_q);
        assign w_commit[i] = w_hit && (w_match ? ((cnt_q + 3'd1) == c_STABLE)
                                               : (c_STABLE == 3'd1));

        always_ff @(posedge clk) begin
            if (rst) begin
                cand_q <= '1;
                cnt_q  <= '0;
            end else if (w_hit) begin
                if (w_match) begin
                    if (cnt_q != c_STABLE) cnt_q <= cnt_q + 3'd1;
                end else begin
                    cand_q <= w_pat;
                    cnt_q  <= 3'd1;
                end
            end
        end

        // An invalid commit flags the digit but keeps its last good value
        always_ff @(posedge clk) begin
            if (rst) begin
                val_q   <= '0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (w_commit[i]) begin
                valid_q <= 1'b1;
                if (w_dec[4]) begin
                    val_q <= w_dec[3:0];
                    err_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end

`ifdef SEG7_DP_EN
        logic dpo_q;
        always_ff @(posedge clk) begin
            if (rst)              dpo_q <= 1'b0;
            else if (w_commit[i]) dpo_q <= ~w_pat[7];
        end
        assign dp_out[i] = dpo_q;
`endif

        assign digits[4*i +: 4] = val_q;
        assign digit_valid[i]   = valid_q;
        assign digit_err[i]     = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) update_q <= 1'b0;
        else     update_q <= |w_commit;
    end

    assign update = update_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// Directed bench for seg7_scan_decoder at default parameters.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        update;

    int n_vec = 0;
    int n_err = 0;
    int upd_cnt = 0;
    int base;

    logic [6:0] pat [4];

    seg7_scan_decoder u_dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .update      (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && update) upd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        dwell(4'hF, 7'h7F, n);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        pat[0] = 7'b0001110;  // F
        pat[1] = 7'b1000000;  // 0
        pat[2] = 7'b0001000;  // A
        pat[3] = 7'b1111000;  // 7

        rst    = 1'b1;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid",  32'(digit_valid), 32'h0);
        chk("rst_err",    32'(digit_err), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        rst = 1'b0;
        idle(3);

        // Digit 0 showing "2", three dwells separated by idle gaps
        base = upd_cnt;
        dwell(4'b1110, 7'b0100100, 10); idle(5);
        dwell(4'b1110, 7'b0100100, 10); idle(5);
        chk("t1_no_commit_yet", 32'(digit_valid[0]), 32'h0);
        dwell(4'b1110, 7'b0100100, 3);
        chk("t1_upd_before", 32'(update), 32'h0);
        @(negedge clk);
        chk("t1_upd_pulse", 32'(update), 32'h1);
        chk("t1_digit_at_pulse", 32'(digits[3:0]), 32'h2);
        @(negedge clk);
        chk("t1_upd_after", 32'(update), 32'h0);
        dwell(4'b1110, 7'b0100100, 5); idle(5);
        chk("t1_digit", 32'(digits[3:0]), 32'h2);
        chk("t1_valid", 32'(digit_valid[0]), 32'h1);
        chk("t1_err",   32'(digit_err[0]), 32'h0);
        chk("t1_updates", 32'(upd_cnt - base), 32'd1);

        // Full back-to-back scan, three rounds
        do_reset();
        base = upd_cnt;
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 4; d++)
                dwell(4'(~(4'b0001 << d)), pat[d], 8);
        idle(5);
        chk("t2_digits",  32'(digits), 32'h7A0F);
        chk("t2_valid",   32'(digit_valid), 32'hF);
        chk("t2_err",     32'(digit_err), 32'h0);
        chk("t2_updates", 32'(upd_cnt - base), 32'd4);

        // Candidate replacement restarts the match count
        do_reset();
        base = upd_cnt;
        dwell(4'b1101, 7'b1000000, 10); idle(3);
        dwell(4'b1101, 7'b1000000, 10); idle(3);
        dwell(4'b1101, 7'b1111001, 10); idle(3);
        dwell(4'b1101, 7'b1111001, 10); idle(3);
        chk("t3_no_commit",  32'(digit_valid[1]), 32'h0);
        chk("t3_no_update",  32'(upd_cnt - base), 32'd0);
        dwell(4'b1101, 7'b1111001, 10); idle(3);
        chk("t3_digit",   32'(digits[7:4]), 32'h1);
        chk("t3_valid",   32'(digit_valid[1]), 32'h1);
        chk("t3_updates", 32'(upd_cnt - base), 32'd1);

        // Blank after a committed 5 flags an error, keeps the value
        do_reset();
        base = upd_cnt;
        for (int k = 0; k < 3; k++) begin
            dwell(4'b1011, 7'b0010010, 10); idle(3);
        end
        chk("t4_digit5", 32'(digits[11:8]), 32'h5);
        chk("t4_err0",   32'(digit_err[2]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            dwell(4'b1011, 7'b1111111, 10); idle(3);
        end
        chk("t4_err1",    32'(digit_err[2]), 32'h1);
        chk("t4_keep5",   32'(digits[11:8]), 32'h5);
        chk("t4_valid",   32'(digit_valid[2]), 32'h1);
        chk("t4_updates", 32'(upd_cnt - base), 32'd2);

        // Short dwells and a multi-low anode never sample
        do_reset();
        base = upd_cnt;
        for (int r = 0; r < 6; r++)
            for (int d = 0; d < 4; d++)
                dwell(4'(~(4'b0001 << d)), pat[d], 2);
        dwell(4'b1100, 7'b0100100, 20);
        idle(5);
        chk("t5_updates", 32'(upd_cnt - base), 32'd0);
        chk("t5_valid",   32'(digit_valid), 32'h0);

        // Reset mid-dwell discards two matching samples
        do_reset();
        base = upd_cnt;
        dwell(4'b0111, 7'b1111000, 10); idle(3);
        dwell(4'b0111, 7'b1111000, 10); idle(3);
        dwell(4'b0111, 7'b1111000, 1);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
        chk("t6_rst_digits", 32'(digits), 32'h0);
        chk("t6_rst_valid",  32'(digit_valid), 32'h0);
        chk("t6_rst_err",    32'(digit_err), 32'h0);
        chk("t6_rst_update", 32'(update), 32'h0);
        idle(3);
        dwell(4'b0111, 7'b1111000, 10); idle(3);
        dwell(4'b0111, 7'b1111000, 10); idle(3);
        chk("t6_no_commit", 32'(digit_valid[3]), 32'h0);
        dwell(4'b0111, 7'b1111000, 10); idle(3);
        chk("t6_digit",   32'(digits[15:12]), 32'h7);
        chk("t6_valid",   32'(digit_valid[3]), 32'h1);
        chk("t6_updates", 32'(upd_cnt - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
